// File: rtl/rr_mux_arbiter_pkg.sv
// Shared sizing helpers for the round-robin mux arbiter slice.
package rr_mux_arbiter_pkg;

  // Bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_INPUT.
module rr_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter int NUM_INPUT = 4
) (
  input  logic [NUM_INPUT-1:0]        request,
  input  logic [clog2(NUM_INPUT)-1:0] ptr,
  output logic [clog2(NUM_INPUT)-1:0] grant,
  output logic                        grant_valid
);

  localparam int SEL_W = clog2(NUM_INPUT);

  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] pos;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    pos         = '0;
    // ptr + k stays below 2*NUM_INPUT, so a single subtraction wraps it
    for (int unsigned k = 1; k <= NUM_INPUT; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_INPUT) idx = idx - NUM_INPUT;
      pos = SEL_W'(idx);
      if (!grant_valid && request[pos]) begin
        grant       = pos;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N:1 data mux, with optional burst lock and a
// one-entry registered output stage.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int BIT_WIDTH = 8,
  parameter int BURST_LEN = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUT-1:0]           in_valid,
  input  logic [NUM_INPUT*BIT_WIDTH-1:0] in_data,
  output logic [NUM_INPUT-1:0]           in_ready,
  output logic                           out_valid,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic [clog2(NUM_INPUT)-1:0]    out_src,
  input  logic                           out_ready
);

  localparam int SEL_W = clog2(NUM_INPUT);
  localparam int CNT_W = clog2(BURST_LEN + 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e          state, state_next;
  logic [SEL_W-1:0]     ptr, ptr_next, rr_grant, grant;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 rr_valid, lock_hold, load_en, xfer;
  logic [BIT_WIDTH-1:0] sel_data;

  rr_pick #(.NUM_INPUT(NUM_INPUT)) u_pick (
    .request     (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= SEL_W'(NUM_INPUT - 1);
      cnt   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
    end
  end

  // While locked, ptr doubles as the lock owner; it was set when the lock began.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          ptr_next = grant;
          cnt_next = CNT_W'(1);
          if (BURST_LEN > 1) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (load_en) begin
          if (lock_hold) begin
            if (cnt + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end else if (xfer) begin
            ptr_next   = grant;
            cnt_next   = CNT_W'(1);
            state_next = (BURST_LEN > 1) ? LOCKED : IDLE;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lock_hold = (state == LOCKED) && in_valid[ptr];
    grant     = lock_hold ? ptr : rr_grant;
    load_en   = !out_valid || out_ready;
    xfer      = load_en && rr_valid;
    in_ready  = '0;
    if (xfer) in_ready[grant] = 1'b1;
    sel_data  = in_data[int'(grant)*BIT_WIDTH +: BIT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: three instances (4/burst1, 4/burst2, 3/burst1) against a rule-level model.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]  va, ra, vb, rb;
  logic [2:0]  vc, rc;
  logic [31:0] da, db;
  logic [23:0] dc;
  logic        orda, ordb, ordc, ova, ovb, ovc;
  logic [7:0]  oda, odb, odc;
  logic [1:0]  osa, osb, osc;

  rr_mux_arbiter #(.NUM_INPUT(4), .BIT_WIDTH(8), .BURST_LEN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da), .in_ready(ra),
    .out_valid(ova), .out_data(oda), .out_src(osa), .out_ready(orda));
  rr_mux_arbiter #(.NUM_INPUT(4), .BIT_WIDTH(8), .BURST_LEN(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db), .in_ready(rb),
    .out_valid(ovb), .out_data(odb), .out_src(osb), .out_ready(ordb));
  rr_mux_arbiter #(.NUM_INPUT(3), .BIT_WIDTH(8), .BURST_LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_data(dc), .in_ready(rc),
    .out_valid(ovc), .out_data(odc), .out_src(osc), .out_ready(ordc));

  // Model state per instance: last winner, burst owner flag/count, output register.
  int m_n[3]  = '{4, 4, 3};
  int m_bl[3] = '{1, 2, 1};
  int m_ptr[3];
  bit m_lock[3];
  int m_cnt[3];
  bit m_ov[3];
  int m_od[3];
  int m_os[3];

  function automatic logic [3:0] cur_v(int k);
    case (k)
      0: return va;
      1: return vb;
      default: return {1'b0, vc};
    endcase
  endfunction

  function automatic logic [31:0] cur_d(int k);
    case (k)
      0: return da;
      1: return db;
      default: return {8'h00, dc};
    endcase
  endfunction

  function automatic bit cur_r(int k);
    case (k)
      0: return orda;
      1: return ordb;
      default: return ordc;
    endcase
  endfunction

  function automatic logic [3:0] dut_ready(int k);
    case (k)
      0: return ra;
      1: return rb;
      default: return {1'b0, rc};
    endcase
  endfunction

  function automatic logic [31:0] dut_ov(int k);
    case (k)
      0: return {31'd0, ova};
      1: return {31'd0, ovb};
      default: return {31'd0, ovc};
    endcase
  endfunction

  function automatic logic [31:0] dut_od(int k);
    case (k)
      0: return {24'd0, oda};
      1: return {24'd0, odb};
      default: return {24'd0, odc};
    endcase
  endfunction

  function automatic logic [31:0] dut_os(int k);
    case (k)
      0: return {30'd0, osa};
      1: return {30'd0, osb};
      default: return {30'd0, osc};
    endcase
  endfunction

  function automatic bit bit_of(logic [3:0] v, int i);
    return v[2'(i)];
  endfunction

  // Owner keeps the grant while it stays valid; otherwise scan after the last winner.
  function automatic int model_grant(int k, logic [3:0] v);
    if (m_lock[k] && bit_of(v, m_ptr[k])) return m_ptr[k];
    for (int s = 1; s <= m_n[k]; s++) begin
      if (bit_of(v, (m_ptr[k] + s) % m_n[k])) return (m_ptr[k] + s) % m_n[k];
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k]  = m_n[k] - 1;
      m_lock[k] = 1'b0;
      m_cnt[k]  = 0;
      m_ov[k]   = 1'b0;
      m_od[k]   = 0;
      m_os[k]   = 0;
    end
  endtask

  task automatic model_step(int k);
    logic [3:0] v;
    int g;
    bit hold, le;
    v    = cur_v(k);
    g    = model_grant(k, v);
    hold = m_lock[k] && bit_of(v, m_ptr[k]);
    le   = !m_ov[k] || cur_r(k);
    if (g >= 0 && le) begin
      if (hold) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == m_bl[k]) begin
          m_lock[k] = 1'b0;
          m_cnt[k]  = 0;
        end
      end else begin
        m_ptr[k]  = g;
        m_cnt[k]  = 1;
        m_lock[k] = (m_bl[k] > 1);
      end
      m_ov[k] = 1'b1;
      m_od[k] = int'((cur_d(k) >> (8 * g)) & 32'hFF);
      m_os[k] = g;
    end else begin
      if (le && m_lock[k]) begin
        m_lock[k] = 1'b0;
        m_cnt[k]  = 0;
      end
      if (cur_r(k)) m_ov[k] = 1'b0;
    end
  endtask

  task automatic chk(string what, int k, logic [31:0] act, logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s inst%0d: got %0h want %0h at %0t", what, k, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int k = 0; k < 3; k++) begin
          int g;
          logic [3:0] er;
          g  = model_grant(k, cur_v(k));
          er = '0;
          if (g >= 0 && (!m_ov[k] || cur_r(k))) er = 4'(1) << g;
          chk("in_ready", k, {28'd0, dut_ready(k)}, {28'd0, er});
          chk("out_valid", k, dut_ov(k), {31'd0, m_ov[k]});
          chk("out_data", k, dut_od(k), 32'(m_od[k]));
          chk("out_src", k, dut_os(k), 32'(m_os[k]));
        end
      end
    end
  end

  initial begin
    int exp_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_b[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int exp_c[8] = '{0, 1, 2, 0, 1, 2, 0, 1};
    int exp_a2[4] = '{1, 3, 1, 3};
    int exp_b2[4] = '{0, 0, 1, 2};

    rst_n = 1'b0;
    va = '0; vb = '0; vc = '0;
    da = 32'h13121110; db = 32'h13121110; dc = 24'h121110;
    orda = 1'b1; ordb = 1'b1; ordc = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, dut_ov(k), 32'd0);
      chk("rst_data", k, dut_od(k), 32'd0);
      chk("rst_src", k, dut_os(k), 32'd0);
    end

    #1 rst_n = 1'b1; va = 4'hF; vb = 4'hF; vc = 3'h7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("p1_src", 0, {30'd0, osa}, 32'(exp_a[i]));
      chk("p1_data", 0, {24'd0, oda}, 32'(8'h10 + exp_a[i]));
      chk("p1_valid", 0, {31'd0, ova}, 32'd1);
      chk("p1_burst_src", 1, {30'd0, osb}, 32'(exp_b[i]));
      chk("p1_n3_src", 2, {30'd0, osc}, 32'(exp_c[i]));
    end

    #1 va = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("p2_src", 0, {30'd0, osa}, 32'(exp_a2[i]));
      chk("p2_ready_mask", 0, {28'd0, ra & 4'b0101}, 32'd0);
      chk("p2_burst_src", 1, {30'd0, osb}, 32'(exp_b2[i]));
      if (i == 2) #1 vb = 4'b1101;
    end

    // instance 1 is mid-burst with a word held when reset hits
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_valid", k, dut_ov(k), 32'd0);
      chk("mid_rst_data", k, dut_od(k), 32'd0);
      chk("mid_rst_src", k, dut_os(k), 32'd0);
    end
    @(negedge clk);
    #1 va = 4'hF; vb = 4'hF; vc = 3'h7; rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_rst_src", k, dut_os(k), 32'd0);

    @(negedge clk);
    chk("p3_src", 0, {30'd0, osa}, 32'd1);
    @(negedge clk);
    chk("p3_src", 0, {30'd0, osa}, 32'd2);
    chk("p3_data", 0, {24'd0, oda}, 32'h12);
    #1 orda = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 0, {31'd0, ova}, 32'd1);
      chk("stall_data", 0, {24'd0, oda}, 32'h12);
      chk("stall_src", 0, {30'd0, osa}, 32'd2);
      chk("stall_ready", 0, {28'd0, ra}, 32'd0);
    end
    #1 orda = 1'b1;
    @(negedge clk);
    chk("release_src", 0, {30'd0, osa}, 32'd3);
    chk("release_data", 0, {24'd0, oda}, 32'h13);
    chk("release_valid", 0, {31'd0, ova}, 32'd1);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      #1;
      va   = 4'($urandom_range(0, 15));
      vb   = 4'($urandom_range(0, 15));
      vc   = 3'($urandom_range(0, 7));
      da   = $urandom;
      db   = $urandom;
      dc   = 24'($urandom);
      orda = ($urandom_range(0, 3) != 0);
      ordb = ($urandom_range(0, 3) != 0);
      ordc = ($urandom_range(0, 3) != 0);
      if (c == 300) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data mux among NUM_INPUT valid/ready requesters.
- Drives the mux select and registers the winning word into a one-entry output stage.
- Supports an optional burst lock, so a winner may keep the grant for up to BURST_LEN consecutive transfers.
- Sits between parallel producers (e.g. PE/buffer lanes) and a single shared consumer port.

Parameters:
- NUM_INPUT, 4: number of requesters; must be >= 2.
- BIT_WIDTH, 8: bits per data word.
- BURST_LEN, 1: maximum consecutive grants to one requester before forced rotation; must be >= 1. A value of 1 gives pure round-robin.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_INPUT  per-requester valid; bit i belongs to requester i.
- in_data  input  NUM_INPUT*BIT_WIDTH  flattened data; requester i occupies [i*BIT_WIDTH +: BIT_WIDTH].
- in_ready  output  NUM_INPUT  per-requester accept; one-hot or zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  BIT_WIDTH  registered winning word.
- out_src  output  clog2(NUM_INPUT)  index of the requester that supplied out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=NUM_INPUT-1, so requester 0 has first priority.
  - Lock state=IDLE, burst counter cnt=0.
- load_en = !out_valid | out_ready. The output stage is free, or is drained in the same cycle.
- Transfer on input i when in_valid[i] & in_ready[i].
- in_ready[i] = load_en & (grant == i) & any_valid. At most one bit is set, and it is combinational from in_valid, state and out_ready.
- Round-robin pick:
  - The winner is the first asserted in_valid searching ptr+1, ptr+2, ..., wrapping modulo NUM_INPUT.
  - If no in_valid is asserted there is no grant, and all in_ready are 0.
- Lock FSM:
  - IDLE: on a transfer from winner w:
    - ptr <= w; cnt <= 1.
    - If BURST_LEN>1, go to LOCKED(w).
    - Otherwise stay in IDLE; ptr advancing to w makes w lowest priority next cycle.
  - LOCKED(w), in_valid[w]=1: grant=w, regardless of other requesters.
    - On a transfer, cnt <= cnt+1.
    - If cnt+1 == BURST_LEN, go to IDLE with cnt <= 0.
  - LOCKED(w), in_valid[w]=0: the lock is released in that same cycle.
    - Normal round-robin pick from ptr=w, so w has lowest priority.
    - Any resulting transfer follows the IDLE rules.
  - LOCKED with load_en=0: no transfer, state and cnt are held.
- Output stage:
  - On a transfer: out_data <= in_data[grant], out_src <= grant, out_valid <= 1.
  - Else if out_ready: out_valid <= 0. out_data and out_src hold their previous values.
- Timing and ordering:
  - Latency is 1 cycle from input handshake to out_valid.
  - Full throughput: one word per cycle while out_ready=1 and any requester is valid.
  - The output must not drop or duplicate words under backpressure.
  - out_data and out_src are stable while out_valid & !out_ready.
- Widths:
  - cnt is clog2(BURST_LEN+1) bits.
  - Pointer arithmetic wraps modulo NUM_INPUT, including non-power-of-two NUM_INPUT; ptr never takes values >= NUM_INPUT.
- Simultaneous events:
  - All valids high: strict rotation 0,1,2,3,0... when BURST_LEN=1.
  - out_ready and a new transfer in the same cycle: the new word replaces the old word with no bubble.
- Reset mid-operation: any in-flight output word is discarded, and the lock and pointer return to reset values immediately.

Decomposition:
- Shared include functions.v supplies clog2. Sizing is via localparams derived from it:
  - SEL_W = clog2(NUM_INPUT).
  - CNT_W = clog2(BURST_LEN+1).
- Lock state encoding is a local 1-bit localparam (IDLE=0, LOCKED=1), not shared.
- One natural combinational sub-module, rr_pick:
  - Parameters NUM_INPUT.
  - Inputs: request vector, ptr.
  - Outputs: grant index, grant_valid.
- Data selection instantiates the codebase's generic mux, using in_data and select=grant.

Test Plan:
- Reset, then in_valid=4'b1111, out_ready=1, BURST_LEN=1, data i=8'h10+i -> out_src sequence 0,1,2,3,0; out_data 10,11,12,13,10; out_valid stays high every cycle after the first.
- in_valid=4'b1010 held, out_ready=1 -> out_src alternates 1,3,1,3; in_ready never asserts on bits 0 or 2.
- BURST_LEN=2, all valid -> out_src 0,0,1,1,2,2,3,3. Then drop in_valid[1] after its first grant -> that burst ends early and the next out_src is 2.
- Output stalled (out_ready=0) for 3 cycles with word 8'h12 from src 2 -> out_data=12 and out_src=2 held stable; in_ready=0. On release, 12 is consumed and a new word loads the same cycle.
- rst_n pulsed low while LOCKED with out_valid=1 -> outputs go to 0 asynchronously. The first post-reset grant goes to requester 0 when all are valid.
- NUM_INPUT=3 instance, all valid -> out_src 0,1,2,0,1; ptr never reaches 3.
